// File: rtl/wdt_pkg.sv
// Shared constants for the watchdog control block: register offsets,
// CTRL bit positions and the bus FSM state encoding.
package wdt_pkg;

   localparam logic [11:0] ADDR_CTRL   = 12'h100;
   localparam logic [11:0] ADDR_LIVE   = 12'h200;
   localparam logic [11:0] ADDR_TOCNT  = 12'h300;
   localparam logic [11:0] ADDR_STATUS = 12'h400;

   localparam int CTRL_WDEN_BIT   = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } wdt_state_t;

   function automatic logic addr_aligned(input logic [11:0] addr);
      return (addr[1:0] == 2'd0);
   endfunction

endpackage

// File: rtl/wdt_ctrl_if.sv
// Request/response register bus between a requester (master) and the
// watchdog control block (slave).
interface wdt_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/wdt_live_stretch.sv
// Retriggerable kick stretcher: a kick (re)loads the hold counter and the
// live output stays high while the counter is nonzero.
module wdt_live_stretch #(
   parameter int unsigned LIVE_HOLD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   output logic live
);

   localparam logic [3:0] HOLD = LIVE_HOLD[3:0];

   logic [3:0] cnt_r;
   logic [3:0] cnt_s;
   logic       live_r;

   // Next hold count: reload on kick, otherwise count down to zero.
   always_comb begin
      cnt_s = cnt_r;
      if (kick) begin
         cnt_s = HOLD;
      end else if (cnt_r != 4'd0) begin
         cnt_s = cnt_r - 4'd1;
      end else begin
         cnt_s = 4'd0;
      end
   end

   // Counter and its registered nonzero flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r  <= 4'd0;
         live_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_s;
         live_r <= (cnt_s != 4'd0);
      end
   end

   assign live = live_r;

endmodule

// File: rtl/wdt_ctrl.sv
// Register front-end for an external watchdog: three-state bus FSM,
// CTRL/LIVE/TOCNT/STATUS registers, TOCNT lock and timeout interrupt.
module wdt_ctrl
   import wdt_pkg::*;
#(
   parameter int unsigned LIVE_HOLD = 4,
   parameter logic [31:0] TOCNT_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   wdt_ctrl_if.slave   bus,
   output logic        WDEN,
   output logic        WDLIVE,
   output logic [31:0] WTOCNT,
   input  logic        WTO,
   output logic        wto_irq
);

   wdt_state_t  state_r;
   wdt_state_t  state_s;
   logic        accept_s;
   logic        exec_s;

   logic        req_ready_r;
   logic        write_r;
   logic [11:0] addr_r;
   logic [31:0] wdata_r;

   logic        resp_valid_r;
   logic [31:0] rdata_r;
   logic        err_r;

   logic        wden_r;
   logic        irq_en_r;
   logic [31:0] wtocnt_r;
   logic        sticky_r;
   logic        irq_r;

   logic [31:0] rd_s;
   logic        err_s;
   logic        ctrl_we_s;
   logic        tocnt_we_s;
   logic        kick_s;
   logic        sticky_clr_s;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state plus the accept/execute strobes.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      exec_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_ready_r && bus.req_valid) begin
               state_s  = ST_EXEC;
               accept_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_s = ST_RESP;
            exec_s  = 1'b1;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Request capture so the requester is free once accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         write_r <= 1'b0;
         addr_r  <= 12'd0;
         wdata_r <= 32'd0;
      end else if (accept_s) begin
         write_r <= bus.req_write;
         addr_r  <= bus.req_addr;
         wdata_r <= bus.req_wdata;
      end
   end

   // Decode of the captured request; the strobes take effect only in EXEC.
   always_comb begin
      rd_s         = 32'd0;
      err_s        = 1'b0;
      ctrl_we_s    = 1'b0;
      tocnt_we_s   = 1'b0;
      kick_s       = 1'b0;
      sticky_clr_s = 1'b0;
      if (!addr_aligned(addr_r)) begin
         err_s = 1'b1;
      end else begin
         case (addr_r)
            ADDR_CTRL: begin
               if (write_r) begin
                  ctrl_we_s = 1'b1;
               end else begin
                  rd_s[CTRL_WDEN_BIT]   = wden_r;
                  rd_s[CTRL_IRQ_EN_BIT] = irq_en_r;
               end
            end
            ADDR_LIVE: begin
               if (write_r) begin
                  kick_s = wdata_r[0];
               end else begin
                  rd_s = 32'd0;
               end
            end
            ADDR_TOCNT: begin
               if (write_r) begin
                  // Threshold is locked while the watchdog runs.
                  if (wden_r) begin
                     err_s = 1'b1;
                  end else begin
                     tocnt_we_s = 1'b1;
                  end
               end else begin
                  rd_s = wtocnt_r;
               end
            end
            ADDR_STATUS: begin
               if (write_r) begin
                  sticky_clr_s = wdata_r[0];
               end else begin
                  rd_s[0] = sticky_r;
               end
            end
            default: err_s = 1'b1;
         endcase
      end
   end

   // Handshake outputs; the response is frozen until it is taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         rdata_r      <= 32'd0;
         err_r        <= 1'b0;
      end else begin
         req_ready_r <= (state_s == ST_IDLE);
         if (exec_s) begin
            resp_valid_r <= 1'b1;
            rdata_r      <= rd_s;
            err_r        <= err_s;
         end else if ((state_r == ST_RESP) && bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
            err_r        <= 1'b0;
         end
      end
   end

   // Control registers and the timeout sticky bit (a live WTO beats a clear).
   always_ff @(posedge clk) begin
      if (!rst) begin
         wden_r   <= 1'b0;
         irq_en_r <= 1'b0;
         wtocnt_r <= TOCNT_RST;
         sticky_r <= 1'b0;
         irq_r    <= 1'b0;
      end else begin
         if (exec_s && ctrl_we_s) begin
            wden_r   <= wdata_r[CTRL_WDEN_BIT];
            irq_en_r <= wdata_r[CTRL_IRQ_EN_BIT];
         end
         if (exec_s && tocnt_we_s) begin
            wtocnt_r <= wdata_r;
         end
         sticky_r <= WTO | (sticky_r & ~(exec_s & sticky_clr_s));
         irq_r    <= sticky_r & irq_en_r;
      end
   end

   wdt_live_stretch #(
      .LIVE_HOLD (LIVE_HOLD)
   ) u_live (
      .clk  (clk),
      .rst  (rst),
      .kick (exec_s & kick_s),
      .live (WDLIVE)
   );

   assign bus.req_ready  = req_ready_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_rdata = rdata_r;
   assign bus.resp_err   = err_r;
   assign WDEN           = wden_r;
   assign WTOCNT         = wtocnt_r;
   assign wto_irq        = irq_r;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Scoreboard bench for wdt_ctrl: a register-map reference model predicts each
// response, and independent monitors check responses and WDLIVE pulse lengths.
module tb_wdt_ctrl;

   localparam int          LIVE_HOLD = 4;
   localparam logic [31:0] TOCNT_RST = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wto = 1'b0;
   logic        wden;
   logic        wdlive;
   logic        wto_irq;
   logic [31:0] wtocnt;

   wdt_ctrl_if bus();

   wdt_ctrl #(.LIVE_HOLD(LIVE_HOLD), .TOCNT_RST(TOCNT_RST)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .WDEN    (wden),
      .WDLIVE  (wdlive),
      .WTOCNT  (wtocnt),
      .WTO     (wto),
      .wto_irq (wto_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        wden;
      logic [31:0] tocnt;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   live_exp[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   bp_mode  = 1;

   // reference model state
   logic        m_wden, m_irq_en, m_sticky;
   logic [31:0] m_tocnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_wden = 1'b0; m_irq_en = 1'b0; m_sticky = 1'b0; m_tocnt = TOCNT_RST;
   endfunction

   function automatic void model_access(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                                        output logic [31:0] rd, output logic err, output logic kick);
      rd = 32'd0; err = 1'b0; kick = 1'b0;
      if (a[1:0] != 2'd0 || !(a inside {12'h100, 12'h200, 12'h300, 12'h400})) begin
         err = 1'b1;
      end else if (a == 12'h100) begin
         if (wr) begin m_wden = wd[0]; m_irq_en = wd[1]; end
         else rd = {30'd0, m_irq_en, m_wden};
      end else if (a == 12'h200) begin
         if (wr) kick = wd[0];
      end else if (a == 12'h300) begin
         if (wr && m_wden) err = 1'b1;
         else if (wr) m_tocnt = wd;
         else rd = m_tocnt;
      end else begin
         if (wr && wd[0] && !wto) m_sticky = 1'b0;
         else if (!wr) rd = {31'd0, m_sticky};
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input string name, output logic kick);
      exp_t e;
      logic [31:0] rd;
      logic er;
      bit ok = 1'b0;
      model_access(wr, a, wd, rd, er, kick);
      e.rdata = rd; e.err = er; e.wden = m_wden; e.tocnt = m_tocnt; e.name = name;
      sb.push_back(e);
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin n_checks++; n_fail++; $display("FAIL %s_accept: req_ready never seen", name); end
      @(posedge clk); #1;
      // scramble the request lines; the DUT must have captured them
      bus.req_valid = 1'b0; bus.req_write = 1'($urandom);
      bus.req_addr = 12'($urandom); bus.req_wdata = $urandom;
   endtask

   task automatic wait_resp(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.resp_valid && bus.resp_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin n_checks++; n_fail++; $display("FAIL %s_resp: no response handshake", name); end
      @(posedge clk); #1;
   endtask

   task automatic txn(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input string name, output logic kick);
      issue(wr, a, wd, name, kick);
      wait_resp(name);
   endtask

   task automatic pulse_wto();
      wto = 1'b1; m_sticky = 1'b1;
      @(posedge clk); #1;
      wto = 1'b0;
   endtask

   // resp_ready driver: random backpressure, forced high or forced low
   initial begin
      bus.resp_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            1:       bus.resp_ready = 1'b1;
            2:       bus.resp_ready = 1'b0;
            default: bus.resp_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // response monitor: scoreboard pop on handshake, stability while stalled
   initial begin
      logic        stall_prev = 1'b0;
      logic [31:0] rd_prev = 32'd0;
      logic        err_prev = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("stall_valid", 32'(bus.resp_valid), 32'd1);
               check("stall_rdata", bus.resp_rdata, rd_prev);
               check("stall_err", 32'(bus.resp_err), 32'(err_prev));
               check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            end
            if (bus.resp_valid && bus.resp_ready) begin
               if (sb.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_resp: rdata 0x%0h with empty scoreboard", bus.resp_rdata);
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                  check({e.name, "_err"}, 32'(bus.resp_err), 32'(e.err));
                  check({e.name, "_wden"}, 32'(wden), 32'(e.wden));
                  check({e.name, "_wtocnt"}, wtocnt, e.tocnt);
               end
            end
            stall_prev = bus.resp_valid && !bus.resp_ready;
            rd_prev    = bus.resp_rdata;
            err_prev   = bus.resp_err;
         end
      end
   end

   // WDLIVE monitor: compare each completed high run with the expected length
   initial begin
      int run = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            run = 0;
         end else if (wdlive) begin
            run++;
         end else if (run > 0) begin
            if (live_exp.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL live_unexpected: pulse of %0d cycles, none expected", run);
            end else begin
               check("live_len", 32'(run), 32'(live_exp.pop_front()));
            end
            run = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic        k;
      logic        wr;
      logic [11:0] a;
      logic [31:0] wd;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 12'd0; bus.req_wdata = 32'd0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_rdata", bus.resp_rdata, 32'd0);
      check("rst_err", 32'(bus.resp_err), 32'd0);
      check("rst_wden", 32'(wden), 32'd0);
      check("rst_wdlive", 32'(wdlive), 32'd0);
      check("rst_wtocnt", wtocnt, TOCNT_RST);
      check("rst_irq", 32'(wto_irq), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("ready_after_reset", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;

      // TOCNT write/read and lock
      txn(1'b1, 12'h300, 32'h20, "tocnt_wr", k);
      txn(1'b0, 12'h300, 32'h0, "tocnt_rd", k);
      txn(1'b1, 12'h100, 32'h1, "ctrl_en", k);
      txn(1'b1, 12'h300, 32'h40, "tocnt_locked", k);
      txn(1'b1, 12'h100, 32'h0, "ctrl_dis", k);
      txn(1'b1, 12'h300, 32'h40, "tocnt_unlocked", k);
      txn(1'b0, 12'h100, 32'h0, "ctrl_rd", k);

      // LIVE: single kick, then a retrigger from a back-to-back kick
      txn(1'b1, 12'h200, 32'h1, "live_kick", k);
      live_exp.push_back(LIVE_HOLD);
      idle(LIVE_HOLD + 3);
      // second reload lands 3 cycles after the first (RESP, IDLE, EXEC)
      live_exp.push_back(3 + LIVE_HOLD);
      txn(1'b1, 12'h200, 32'h1, "live_kick_a", k);
      txn(1'b1, 12'h200, 32'h1, "live_kick_b", k);
      idle(LIVE_HOLD + 3);
      txn(1'b1, 12'h200, 32'h2, "live_nop", k);
      txn(1'b0, 12'h200, 32'h0, "live_rd", k);
      idle(LIVE_HOLD + 3);

      // timeout sticky and interrupt
      txn(1'b1, 12'h100, 32'h2, "irq_en", k);
      pulse_wto();
      idle(2);
      check("irq_set", 32'(wto_irq), 32'(m_irq_en & m_sticky));
      txn(1'b0, 12'h400, 32'h0, "status_rd_set", k);
      wto = 1'b1;
      txn(1'b1, 12'h400, 32'h1, "status_clr_vs_wto", k);
      wto = 1'b0;
      txn(1'b0, 12'h400, 32'h0, "status_rd_kept", k);
      txn(1'b1, 12'h400, 32'h1, "status_clr", k);
      txn(1'b0, 12'h400, 32'h0, "status_rd_clr", k);
      idle(2);
      check("irq_clr", 32'(wto_irq), 32'(m_irq_en & m_sticky));

      // error responses, one held under backpressure
      bp_mode = 2;
      issue(1'b0, 12'h104, 32'h0, "rd_104", k);
      @(posedge clk); #1;
      repeat (3) begin
         @(negedge clk);
         check("held_valid", 32'(bus.resp_valid), 32'd1);
         check("held_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bp_mode = 1;
      wait_resp("rd_104");
      txn(1'b0, 12'h500, 32'h0, "rd_500", k);
      txn(1'b1, 12'h500, 32'h1, "wr_500", k);
      txn(1'b1, 12'h302, 32'h77, "wr_misaligned", k);

      // randomized traffic with backpressure
      bp_mode = 0;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    a = 12'h100;
            2:       a = 12'h200;
            3, 4:    a = 12'h300;
            5, 6:    a = 12'h400;
            7:       a = 12'h100 * 12'($urandom_range(1, 4)) + 12'($urandom_range(1, 3));
            8:       a = 12'($urandom_range(0, 4095));
            default: a = 12'h100;
         endcase
         wr = 1'($urandom);
         wd = $urandom;
         txn(wr, a, wd, $sformatf("rand%0d", i), k);
         if (k) begin
            live_exp.push_back(LIVE_HOLD);
            idle(LIVE_HOLD + 1);
         end
         if ($urandom_range(0, 5) == 0) begin
            pulse_wto();
            idle(2);
            check("rand_irq", 32'(wto_irq), 32'(m_irq_en & m_sticky));
         end
      end

      // reset during EXEC of a TOCNT write
      bp_mode = 1;
      txn(1'b1, 12'h100, 32'h0, "pre_rst_dis", k);
      issue(1'b1, 12'h300, 32'h1234_5678, "tocnt_rst", k);
      rst = 1'b0;
      sb.delete(sb.size() - 1);
      model_reset();
      @(posedge clk); @(negedge clk);
      check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("postrst_wtocnt", wtocnt, TOCNT_RST);
      check("postrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("postrst_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;
      txn(1'b0, 12'h300, 32'h0, "postrst_tocnt_rd", k);

      idle(LIVE_HOLD + 3);
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("live_drained", 32'(live_exp.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
